// File: rtl/tail_light_monitor.sv
// Read-back decoder for the tail-light lamp buses: recovers direction and sweep step,
// counts completed sweeps and flags illegal patterns, illegal ordering and stuck sequences.
module tail_light_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 60_000_000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       left_lights,
    input  logic [2:0]       right_lights,
    input  logic             clr,
    output logic [1:0]       dir,
    output logic [1:0]       step,
    output logic             sweep_done,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count,
    output logic             err_illegal,
    output logic             seq_err,
    output logic             stuck_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_BAD
    } state_t;

    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX    = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST   = TW'(TIMEOUT - 1);

    logic [5:0]    sync1, sync2, cand, accepted;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmr;
    logic          accept;
    state_t        state, state_next, pat_state;
    logic          legal, inc_left, inc_right, set_seq, set_ill, set_stuck;

    function automatic state_t decode_pat(input logic [5:0] p);
        case (p)
            6'b000_000: return S_IDLE;
            6'b001_000: return S_L1;
            6'b011_000: return S_L2;
            6'b111_000: return S_L3;
            6'b000_100: return S_R1;
            6'b000_110: return S_R2;
            6'b000_111: return S_R3;
            default:    return S_BAD;
        endcase
    endfunction

    function automatic logic [3:0] decode_out(input state_t s);
        case (s)
            S_L1:    return 4'b01_01;
            S_L2:    return 4'b01_10;
            S_L3:    return 4'b01_11;
            S_R1:    return 4'b10_01;
            S_R2:    return 4'b10_10;
            S_R3:    return 4'b10_11;
            default: return 4'b00_00;
        endcase
    endfunction

    function automatic logic is_active(input state_t s);
        return (s != S_IDLE) && (s != S_BAD);
    endfunction

    // stab_cnt holds the number of consecutive samples equal to cand; the
    // accepting sample is the STABLE_CYCLES-th, so acceptance is combinational.
    assign accept    = (sync2 == cand) && (stab_cnt == STABLE_MAX) && (sync2 != accepted);
    assign pat_state = decode_pat(sync2);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            stab_cnt <= '0;
            accepted <= '0;
        end else begin
            sync1 <= {left_lights, right_lights};
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= SW'(1);
            end else if (stab_cnt != STABLE_MAX) begin
                stab_cnt <= stab_cnt + SW'(1);
            end
            if (accept) accepted <= sync2;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        legal      = 1'b0;
        inc_left   = 1'b0;
        inc_right  = 1'b0;
        set_seq    = 1'b0;
        set_ill    = 1'b0;
        if (accept) begin
            if (pat_state == S_BAD) begin
                state_next = S_BAD;
                set_ill    = 1'b1;
            end else if (pat_state == S_IDLE) begin
                state_next = S_IDLE;
            end else if (state != S_BAD) begin
                legal = ((state == S_IDLE) && (pat_state == S_L1 || pat_state == S_R1)) ||
                        ((state == S_L1) && (pat_state == S_L2)) ||
                        ((state == S_L2) && (pat_state == S_L3)) ||
                        ((state == S_R1) && (pat_state == S_R2)) ||
                        ((state == S_R2) && (pat_state == S_R3));
                state_next = pat_state;
                set_seq    = !legal;
                inc_left   = legal && (state == S_L2);
                inc_right  = legal && (state == S_R2);
            end
        end
    end

    assign set_stuck = !accept && is_active(state_next) && (tmr == TMR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            dir         <= 2'b00;
            step        <= 2'b00;
            tmr         <= '0;
            sweep_done  <= 1'b0;
            left_count  <= '0;
            right_count <= '0;
            err_illegal <= 1'b0;
            seq_err     <= 1'b0;
            stuck_err   <= 1'b0;
        end else begin
            state          <= state_next;
            {dir, step}    <= decode_out(state_next);
            sweep_done     <= inc_left || inc_right;
            if (accept || !is_active(state_next)) begin
                tmr <= '0;
            end else if (tmr != TMR_MAX) begin
                tmr <= tmr + TW'(1);
            end
            // clr wins over a same-cycle increment or error set.
            if (clr) begin
                left_count  <= '0;
                right_count <= '0;
                err_illegal <= 1'b0;
                seq_err     <= 1'b0;
                stuck_err   <= 1'b0;
            end else begin
                if (inc_left && left_count != '1)   left_count  <= left_count + CNT_W'(1);
                if (inc_right && right_count != '1) right_count <= right_count + CNT_W'(1);
                if (set_ill)   err_illegal <= 1'b1;
                if (set_seq)   seq_err     <= 1'b1;
                if (set_stuck) stuck_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tail_light_monitor.sv
// Scoreboard bench for tail_light_monitor: expected output words are queued when a
// pattern is driven and compared when the decoder is due to reflect it.
module tb_tail_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] left_lights = 3'b000;
    logic [2:0] right_lights = 3'b000;
    logic [1:0] dir, step;
    logic       sweep_done;
    logic [1:0] left_count, right_count;
    logic       err_illegal, seq_err, stuck_err;

    tail_light_monitor #(.STABLE_CYCLES(4), .TIMEOUT(1000), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .left_lights(left_lights), .right_lights(right_lights),
        .clr(clr), .dir(dir), .step(step), .sweep_done(sweep_done),
        .left_count(left_count), .right_count(right_count),
        .err_illegal(err_illegal), .seq_err(seq_err), .stuck_err(stuck_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          sd_pulses = 0;
    logic [11:0] exp_q[$];
    logic [11:0] cur = 12'h000;

    always @(posedge clk) if (sweep_done === 1'b1) sd_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word layout: {sweep_done, dir, step, left_count, right_count, err_illegal, seq_err, stuck_err}
    function automatic logic [11:0] obs();
        return {sweep_done, dir, step, left_count, right_count, err_illegal, seq_err, stuck_err};
    endfunction

    function automatic logic [11:0] mk(input logic sd, input logic [1:0] d, input logic [1:0] s,
                                       input logic [1:0] lc, input logic [1:0] rc,
                                       input logic ill, input logic sq, input logic stk);
        return {sd, d, s, lc, rc, ill, sq, stk};
    endfunction

    // Drive a pattern before edge k; outputs must still be old after edge k+4 and
    // new after edge k+5, with any sweep_done pulse gone one edge later.
    task automatic apply(input string tag, input logic [2:0] l, input logic [2:0] r,
                         input logic [11:0] e);
        logic [11:0] want;
        @(negedge clk);
        left_lights  = l;
        right_lights = r;
        exp_q.push_back(e);
        repeat (5) @(posedge clk);
        #1 check({tag, "_early"}, {20'd0, obs()}, {20'd0, cur});
        @(posedge clk);
        #1 want = exp_q.pop_front();
        check(tag, {20'd0, obs()}, {20'd0, want});
        cur = want & 12'h7ff;
        @(posedge clk);
        #1 check({tag, "_hold"}, {20'd0, obs()}, {20'd0, cur});
        repeat (18) @(posedge clk);
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cur = 12'h000;
        #1 check(tag, {20'd0, obs()}, 32'd0);
    endtask

    initial begin
        logic [1:0] rc_prev, rc_new;
        int         sd_base;

        // Reset state
        #2 rst = 1'b0;
        #1 check("reset_state", {20'd0, obs()}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1. Reset mid-sweep
        apply("t1_l1", 3'b001, 3'b000, mk(1'b0, 2'b01, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        apply("t1_l2", 3'b011, 3'b000, mk(1'b0, 2'b01, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        #3 rst = 1'b0;
        left_lights = 3'b000;
        #1 check("t1_rst_async", {20'd0, obs()}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cur = 12'h000;
        repeat (10) @(posedge clk);
        #1 check("t1_rst_idle", {20'd0, obs()}, 32'd0);

        // 2. Clean left sweep (L1 from IDLE without seq_err also proves IDLE after reset)
        apply("t2_l1", 3'b001, 3'b000, mk(1'b0, 2'b01, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        apply("t2_l2", 3'b011, 3'b000, mk(1'b0, 2'b01, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        apply("t2_l3", 3'b111, 3'b000, mk(1'b1, 2'b01, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0));
        apply("t2_idle", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0));

        // 3. Glitch rejection: three cycles of R1 in IDLE
        @(negedge clk);
        right_lights = 3'b100;
        repeat (3) @(negedge clk);
        right_lights = 3'b000;
        repeat (12) @(posedge clk);
        #1 check("t3_glitch", {20'd0, obs()}, {20'd0, cur});

        // 4. Illegal pattern, BAD ignores non-idle patterns, exits on IDLE
        apply("t4_ill", 3'b001, 3'b100, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0));
        apply("t4_bad_l1", 3'b001, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0));
        apply("t4_bad_010", 3'b000, 3'b010, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0));
        apply("t4_idle", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0));
        pulse_clr("t4_clr");

        // 5. Sequence errors and resync
        apply("t5_l2", 3'b011, 3'b000, mk(1'b0, 2'b01, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0));
        apply("t5_l3", 3'b111, 3'b000, mk(1'b1, 2'b01, 2'd3, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0));
        apply("t5_idle", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0));
        apply("t5_r3", 3'b000, 3'b111, mk(1'b0, 2'b10, 2'd3, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0));
        apply("t5_idle2", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0));
        pulse_clr("t5_clr");

        // 6a. Timeout: acceptance edge E; stuck_err after E+1000, not after E+999
        apply("t6_l1", 3'b001, 3'b000, mk(1'b0, 2'b01, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        repeat (980) @(posedge clk);
        #1 check("t6_stuck_early", {31'd0, stuck_err}, 32'd0);
        @(posedge clk);
        #1 check("t6_stuck_set", {31'd0, stuck_err}, 32'd1);
        cur = mk(1'b0, 2'b01, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        apply("t6_idle", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        pulse_clr("t6_clr");

        // 6b. Right-count saturation at 3 with CNT_W=2
        sd_base = sd_pulses;
        rc_prev = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            rc_new = (i >= 3) ? 2'd3 : 2'(i);
            apply("t6_r1", 3'b000, 3'b100, mk(1'b0, 2'b10, 2'd1, 2'd0, rc_prev, 1'b0, 1'b0, 1'b0));
            apply("t6_r2", 3'b000, 3'b110, mk(1'b0, 2'b10, 2'd2, 2'd0, rc_prev, 1'b0, 1'b0, 1'b0));
            apply("t6_r3", 3'b000, 3'b111, mk(1'b1, 2'b10, 2'd3, 2'd0, rc_new, 1'b0, 1'b0, 1'b0));
            apply("t6_ri", 3'b000, 3'b000, mk(1'b0, 2'b00, 2'd0, 2'd0, rc_new, 1'b0, 1'b0, 1'b0));
            rc_prev = rc_new;
        end
        check("t6_sweep_pulses", sd_pulses - sd_base, 32'd4);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
